decoder_scan_seq: RTL

//  Parametrised registered SEL_W-to-2**SEL_W one-hot decoder with an enable and a built-in sweep sequencer.

---
 rtl/decoder_scan_seq_if.sv | 26 ++
 rtl/decoder_scan_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq_if.sv
// Control/status bus for decoder_scan_seq: the master drives select/enable/start,
// the decoder (slave) returns the one-hot lines and sweep status.
interface decoder_scan_seq_if #(
  parameter int SEL_W = 2
) ();
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic             start;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] idx;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, start, sel,
    input  y, idx, busy, done
  );

  modport slave (
    input  en, mode, start, sel,
    output y, idx, busy, done
  );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with manual select and a timed sweep sequencer.
// Build option: define DECODER_SCAN_LOOP_EN for continuous sweeping (start while busy stops it).
module decoder_scan_seq #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scan_seq_if.slave bus
);
  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

`ifdef DECODER_SCAN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             line_on_d;
  logic [N-1:0]     onehot_d;
  logic [N-1:0]     y_q, y_d;

  // Decode of the next index; gated below so at most one line is ever active.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign onehot_d[gi] = (idx_d == SEL_W'(gi));
  end

  assign y_d = line_on_d ? onehot_d : '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    line_on_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.mode) begin
          idx_d     = bus.sel;
          line_on_d = bus.en;
        end else if (bus.en && bus.start) begin
          state_d   = SCAN;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          line_on_d = 1'b1;
        end
      end

      SCAN: begin
        if (LOOP_EN && bus.start) begin
          // Abort of a looping sweep: back to idle quietly, no done pulse.
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (bus.en) begin
          line_on_d = 1'b1;
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d = idx_q + 1'b1;
            end else begin
              idx_d  = '0;
              done_d = 1'b1;
              if (!LOOP_EN) begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                line_on_d = 1'b0;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  // Polarity is applied after the register so reset yields all-inactive in either sense.
  assign bus.y    = (ACTIVE_LOW != 0) ? ~y_q : y_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
